score_arbiter: RTL and testbench
================================

SCORE_ARBITER -- requirements
Module: score_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing the BCD score accumulator (fixed at 4 in this revision).
REQ-002 Parameter DIGITS, default 4: BCD digits in the score (fixed at 4 in this revision).
REQ-003 CLK  input  1  single clock, all state on rising edge.
REQ-004 RESET  input  1  asynchronous, active-low reset.
REQ-005 CLEAR  input  1  synchronous score clear, highest priority.
REQ-006 REQ  input  4  per-requester add request, level, held until ACK.
REQ-007 AMT  input  16  per-requester BCD add amount, AMT[4i+3:4i] for requester i.
REQ-008 ACK  output  4  one-hot, one-cycle completion pulse to the granted requester.
REQ-009 SCORE  output  16  4-digit BCD score, SCORE[3:0] = units.
REQ-010 BUSY  output  1  high whenever the FSM is not IDLE.
REQ-011 OVERFLOW  output  1  sticky flag, carry out of the top digit occurred.

Function
REQ-012 The FSM SHALL have states IDLE, ADD, DONE; ADD SHALL run 4 cycles with a digit index 0..3.
REQ-013 In IDLE with CLEAR low and any REQ high, the next edge SHALL latch the granted index and its AMT nibble, clear the carry, and enter ADD at digit 0.
REQ-014 The grant SHALL be round-robin: search starts at (last granted + 1) mod 4; after reset the pointer SHALL be 3 so requester 0 wins first.
REQ-015 Each ADD cycle SHALL add one digit: digit 0 = SCORE[3:0] + amount + 0, digits 1..3 = SCORE digit + 0 + carry; sum>9 yields sum-10 and carry 1.
REQ-016 An amount nibble >9 SHALL be clamped to 9 at latch time.
REQ-017 Result digits SHALL accumulate in a shadow register; SCORE SHALL update only on the edge entering DONE.
REQ-018 DONE SHALL last exactly one cycle with ACK[grant]=1 and the new SCORE visible; next state IDLE.
REQ-019 Latency: REQ sampled at edge k -> SCORE updated and ACK high after edge k+5; throughput one grant per 6 cycles.
REQ-020 A requester SHALL drop REQ at the edge ending its ACK cycle; REQ dropped early SHALL NOT abort the add, and ACK SHALL still pulse.
REQ-021 A carry out of digit 3 SHALL set OVERFLOW; OVERFLOW SHALL remain set until CLEAR or reset.
REQ-022 CLEAR high at any edge SHALL force SCORE=0000, OVERFLOW=0, state IDLE, no ACK; an in-flight add SHALL be discarded and its requester re-arbitrated later; the round-robin pointer SHALL be unchanged.
REQ-023 ACK SHALL never be asserted outside DONE and never on more than one bit.

Reset
REQ-024 RESET low SHALL asynchronously force state IDLE, SCORE=0000, ACK=0000, BUSY=0, OVERFLOW=0, pointer=3, shadow and carry=0.
REQ-025 Reset release SHALL take effect on the first rising CLK edge with RESET high; reset mid-ADD SHALL discard the add with no ACK.

Configuration
REQ-026 Macro SCORE_ARBITER_SAT_EN defined: on top-digit carry SCORE SHALL saturate to 9999.
REQ-027 Macro SCORE_ARBITER_SAT_EN undefined: SCORE SHALL wrap modulo 10000 (e.g. 9998+5 -> 0003); OVERFLOW behaviour identical in both builds.

Structure
REQ-028 A shared package SHALL hold the FSM state encoding, NUM_REQ, DIGITS, and BCD constants (BCD_MAX_DIGIT=9, SCORE_MAX=16'h9999).
REQ-029 One sub-module bcd_digit_adder SHALL implement the combinational single-digit add (a, b, cin -> sum, cout), instantiated once and time-shared across the 4 ADD cycles.

Verification
REQ-030 Single: SCORE=0000, REQ[0]=1, AMT[3:0]=7 -> ACK=0001 after edge k+5, SCORE=0007, BUSY high for 5 cycles.
REQ-031 Ripple: SCORE=0999, requester 2 adds 1 -> SCORE=1000, OVERFLOW=0.
REQ-032 Fairness: REQ=1111 held, all amounts 1 -> ACK order 0,1,2,3,0; SCORE increments by 1 every 6 cycles.
REQ-033 Overflow: SCORE=9998, add 5 -> SAT_EN build SCORE=9999, else SCORE=0003; OVERFLOW=1 in both; clamp check AMT nibble=F adds 9.
REQ-034 Abort: CLEAR pulsed during ADD digit 2 -> SCORE=0000, OVERFLOW=0, no ACK, requester re-granted and completes afterwards.
REQ-035 Reset: RESET low mid-ADD, asynchronous to CLK -> all outputs zero immediately, first grant after release goes to requester 0.

Source files
------------

// File: rtl/score_arbiter_pkg.sv
// rtl/score_arbiter_pkg.sv - shared constants, FSM encoding and helpers for score_arbiter
//
// Purpose: one place for the requester count, score width, BCD limits and
// the arbiter FSM state encoding, imported by every score_arbiter file.
// Ports: none (package).

package score_arbiter_pkg;

  localparam int NUM_REQ = 4;
  localparam int DIGITS  = 4;

  localparam logic [3:0]  BCD_MAX_DIGIT = 4'd9;
  localparam logic [15:0] SCORE_MAX     = 16'h9999;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Amount nibbles above 9 are not valid BCD; treat them as the largest digit.
  function automatic logic [3:0] clamp_digit(input logic [3:0] d);
    return (d > BCD_MAX_DIGIT) ? BCD_MAX_DIGIT : d;
  endfunction

endpackage

// File: rtl/score_arbiter_bcd_digit_adder.sv
// rtl/score_arbiter_bcd_digit_adder.sv - combinational single BCD digit adder
//
// Purpose: adds two BCD digits and a carry-in, producing a BCD sum digit
// and a decimal carry-out. Inputs are assumed to be valid BCD (0..9).
// Ports:
//   a_i    [3:0]  first BCD digit
//   b_i    [3:0]  second BCD digit
//   cin_i         carry in
//   sum_o  [3:0]  BCD sum digit
//   cout_o        decimal carry out

module bcd_digit_adder
  import score_arbiter_pkg::*;
(
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] sum_o,
  output logic       cout_o
);

  logic [4:0] raw;
  logic [4:0] adj;

  always_comb begin
    raw = {1'b0, a_i} + {1'b0, b_i} + {4'b0000, cin_i};
    adj = raw - 5'd10;
    if (raw > {1'b0, BCD_MAX_DIGIT}) begin
      sum_o  = adj[3:0];
      cout_o = 1'b1;
    end else begin
      sum_o  = raw[3:0];
      cout_o = 1'b0;
    end
  end

endmodule

// File: rtl/score_arbiter.sv
// rtl/score_arbiter.sv - round-robin arbiter feeding a digit-serial BCD score accumulator
//
// Purpose: grants one of NUM_REQ requesters at a time, adds its BCD amount to
// the shared score one digit per cycle through a single time-shared digit
// adder, then pulses ACK to that requester for one cycle.
// Build option: define SCORE_ARBITER_SAT_EN to saturate the score at 9999 on
// overflow; otherwise the score wraps modulo 10000.
// Ports:
//   clk_i               clock, all state on rising edge
//   rst_ni              asynchronous active-low reset
//   clear_i             synchronous score clear, overrides everything else
//   req_i   [NUM_REQ-1:0]    per-requester add request (level, held until ack)
//   amt_i   [4*NUM_REQ-1:0]  per-requester BCD amount, nibble i for requester i
//   ack_o   [NUM_REQ-1:0]    one-hot completion pulse
//   score_o [4*DIGITS-1:0]   BCD score, [3:0] = units
//   busy_o              high whenever the FSM is not idle
//   overflow_o          sticky carry-out-of-top-digit flag

module score_arbiter
  import score_arbiter_pkg::*;
#(
  parameter int NUM_REQ = score_arbiter_pkg::NUM_REQ,
  parameter int DIGITS  = score_arbiter_pkg::DIGITS
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
  input  logic [NUM_REQ-1:0]     req_i,
  input  logic [4*NUM_REQ-1:0]   amt_i,
  output logic [NUM_REQ-1:0]     ack_o,
  output logic [4*DIGITS-1:0]    score_o,
  output logic                   busy_o,
  output logic                   overflow_o
);

  state_e      state_q, state_d;
  logic [1:0]  digit_q, digit_d;
  logic [1:0]  grant_q, grant_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [3:0]  amt_q, amt_d;
  logic        carry_q, carry_d;
  logic [15:0] shadow_q, shadow_d;
  logic [15:0] score_q, score_d;
  logic        ovf_q, ovf_d;

  logic        grant_found;
  logic [1:0]  grant_idx;
  logic [1:0]  cand;

  logic [3:0]  add_a, add_b, add_sum;
  logic        add_cin, add_cout;

  // Round-robin search: candidates ptr+1, ptr+2, ... wrapping, with the last
  // granted requester checked last.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = ptr_q;
    cand        = 2'd0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ptr_q + 2'(k);
      if (!grant_found && req_i[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Digit 0 brings in the amount; higher digits only propagate the carry.
  always_comb begin
    add_a   = score_q[{digit_q, 2'b00} +: 4];
    add_b   = (digit_q == 2'd0) ? amt_q : 4'd0;
    add_cin = (digit_q == 2'd0) ? 1'b0 : carry_q;
  end

  bcd_digit_adder u_digit_adder (
    .a_i    (add_a),
    .b_i    (add_b),
    .cin_i  (add_cin),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

  always_comb begin
    state_d  = state_q;
    digit_d  = digit_q;
    grant_d  = grant_q;
    ptr_d    = ptr_q;
    amt_d    = amt_q;
    carry_d  = carry_q;
    shadow_d = shadow_q;
    score_d  = score_q;
    ovf_d    = ovf_q;

    unique case (state_q)
      ST_IDLE: begin
        if (grant_found) begin
          state_d = ST_ADD;
          digit_d = 2'd0;
          grant_d = grant_idx;
          ptr_d   = grant_idx;
          amt_d   = clamp_digit(amt_i[{grant_idx, 2'b00} +: 4]);
          carry_d = 1'b0;
        end
      end

      ST_ADD: begin
        shadow_d[{digit_q, 2'b00} +: 4] = add_sum;
        carry_d = add_cout;
        if (digit_q == 2'(DIGITS - 1)) begin
          // Publish the whole result at once; the top digit comes straight
          // from the adder since the shadow copy is only written this edge.
          state_d = ST_DONE;
`ifdef SCORE_ARBITER_SAT_EN
          score_d = add_cout ? SCORE_MAX : {add_sum, shadow_q[11:0]};
`else
          score_d = {add_sum, shadow_q[11:0]};
`endif
          if (add_cout) begin
            ovf_d = 1'b1;
          end
        end else begin
          digit_d = digit_q + 2'd1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Clear discards any in-flight add; the requester still holds its request
    // and is simply arbitrated again. The round-robin pointer is kept.
    if (clear_i) begin
      state_d = ST_IDLE;
      score_d = '0;
      ovf_d   = 1'b0;
      ptr_d   = ptr_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      digit_q  <= 2'd0;
      grant_q  <= 2'd0;
      ptr_q    <= 2'd3;
      amt_q    <= 4'd0;
      carry_q  <= 1'b0;
      shadow_q <= 16'h0000;
      score_q  <= 16'h0000;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      digit_q  <= digit_d;
      grant_q  <= grant_d;
      ptr_q    <= ptr_d;
      amt_q    <= amt_d;
      carry_q  <= carry_d;
      shadow_q <= shadow_d;
      score_q  <= score_d;
      ovf_q    <= ovf_d;
    end
  end

  assign ack_o      = (state_q == ST_DONE) ? (NUM_REQ'(1) << grant_q) : '0;
  assign score_o    = score_q;
  assign busy_o     = (state_q != ST_IDLE);
  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_score_arbiter.sv
// tb/tb_score_arbiter.sv - self-checking bench for score_arbiter with a cycle-level reference model

module tb_score_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic [3:0]  req;
  logic [15:0] amt;
  logic [3:0]  ack;
  logic [15:0] score;
  logic        busy;
  logic        ovf;

  always #5 clk = ~clk;

  score_arbiter dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .clear_i    (clear),
    .req_i      (req),
    .amt_i      (amt),
    .ack_o      (ack),
    .score_o    (score),
    .busy_o     (busy),
    .overflow_o (ovf)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    r[15:12] = 4'((v / 1000) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[3:0]   = 4'(v % 10);
    return r;
  endfunction

  // Reference model: decimal integer score, phase 0 idle, 1..4 adding, 5 ack.
  int m_score = 0;
  int m_phase = 0;
  int m_grant = 0;
  int m_ptr   = 3;
  int m_amt   = 0;
  bit m_ovf   = 1'b0;

  always @(posedge clk or negedge rst_n) begin : model
    int  c;
    int  nib;
    int  sum;
    bit  found;
    if (!rst_n) begin
      m_score = 0; m_phase = 0; m_grant = 0; m_ptr = 3; m_amt = 0; m_ovf = 1'b0;
    end else if (clear) begin
      m_score = 0; m_ovf = 1'b0; m_phase = 0;
    end else if (m_phase == 0) begin
      found = 1'b0;
      for (int k = 1; k <= 4; k++) begin
        c = (m_ptr + k) % 4;
        if (!found && req[c]) begin
          found   = 1'b1;
          m_grant = c;
          m_ptr   = c;
          nib     = int'(amt[c*4 +: 4]);
          m_amt   = (nib > 9) ? 9 : nib;
          m_phase = 1;
        end
      end
    end else if (m_phase == 4) begin
      sum = m_score + m_amt;
      if (sum > 9999) begin
        m_ovf = 1'b1;
`ifdef SCORE_ARBITER_SAT_EN
        m_score = 9999;
`else
        m_score = sum - 10000;
`endif
      end else begin
        m_score = sum;
      end
      m_phase = 5;
    end else if (m_phase == 5) begin
      m_phase = 0;
    end else begin
      m_phase = m_phase + 1;
    end
  end

  always @(negedge clk) begin
    chk("ack", {28'd0, ack}, (m_phase == 5) ? (32'd1 << m_grant) : 32'd0);
    chk("score", {16'd0, score}, {16'd0, to_bcd(m_score)});
    chk("busy", {31'd0, busy}, {31'd0, (m_phase != 0)});
    chk("overflow", {31'd0, ovf}, {31'd0, m_ovf});
  end

  task automatic do_add(input int idx, input logic [3:0] nib);
    bit got;
    got = 1'b0;
    @(negedge clk);
    req[idx] = 1'b1;
    amt[idx*4 +: 4] = nib;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (ack[idx]) begin
        got = 1'b1;
        req[idx] = 1'b0;
      end
    end
    chk("ack_seen", {31'd0, got}, 32'd1);
  endtask

  int exp_order[5] = '{0, 1, 2, 3, 0};
  int order[5];
  int at[5];
  int nacks;
  bit got;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    clear = 1'b0;
    req   = 4'b0000;
    amt   = 16'h0000;
    repeat (2) @(negedge clk);
    chk("rst_score", {16'd0, score}, 32'h0000);
    chk("rst_ack", {28'd0, ack}, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single add: requester 0 adds 7, ack after the 5th edge, busy 5 cycles.
    req = 4'b0001;
    amt = 16'h0007;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      chk("single_busy", {31'd0, busy}, (c <= 5) ? 32'd1 : 32'd0);
      chk("single_ack", {28'd0, ack}, (c == 5) ? 32'h1 : 32'h0);
      if (c == 5) begin
        chk("single_score", {16'd0, score}, 32'h0007);
        req = 4'b0000;
      end
    end

    // Asynchronous reset in the middle of an add from requester 2.
    @(negedge clk);
    req = 4'b0100;
    amt = 16'h0300;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_score", {16'd0, score}, 32'h0000);
    chk("arst_ack", {28'd0, ack}, 32'h0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_ovf", {31'd0, ovf}, 32'd0);
    req = 4'b0000;
    amt = 16'h0000;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Fairness: all four requesting, amount 1 each.
    @(negedge clk);
    req = 4'b1111;
    amt = 16'h1111;
    nacks = 0;
    for (int c = 1; c <= 60 && nacks < 5; c++) begin
      @(negedge clk);
      if (ack != 4'b0000) begin
        for (int b = 0; b < 4; b++) if (ack[b]) order[nacks] = b;
        at[nacks] = c;
        nacks++;
      end
    end
    req = 4'b0000;
    chk("fair_count", nacks, 5);
    for (int i = 0; i < 5; i++) begin
      chk("fair_order", order[i], exp_order[i]);
      chk("fair_gap", (i == 0) ? at[0] : at[i] - at[i-1], (i == 0) ? 5 : 6);
    end
    chk("fair_score", {16'd0, score}, 32'h0005);

    // Ripple: build 0999, then requester 2 adds 1.
    for (int n = 0; n < 110; n++) do_add(n % 4, (n % 3 == 0) ? 4'hF : 4'h9);
    do_add(3, 4'h4);
    chk("pre_ripple", {16'd0, score}, 32'h0999);
    do_add(2, 4'h1);
    chk("ripple_score", {16'd0, score}, 32'h1000);
    chk("ripple_ovf", {31'd0, ovf}, 32'd0);

    // Overflow: build 9998, add 5, then add a clamped F.
    for (int n = 0; n < 999; n++) do_add(n % 4, 4'h9);
    do_add(1, 4'h7);
    chk("pre_ovf", {16'd0, score}, 32'h9998);
    do_add(0, 4'h5);
`ifdef SCORE_ARBITER_SAT_EN
    chk("ovf_score", {16'd0, score}, 32'h9999);
`else
    chk("ovf_score", {16'd0, score}, 32'h0003);
`endif
    chk("ovf_flag", {31'd0, ovf}, 32'd1);
    do_add(3, 4'hF);
`ifdef SCORE_ARBITER_SAT_EN
    chk("clamp_score", {16'd0, score}, 32'h9999);
`else
    chk("clamp_score", {16'd0, score}, 32'h0012);
`endif
    chk("ovf_sticky", {31'd0, ovf}, 32'd1);

    // Abort: clear sampled while adding digit 2; requester 1 completes later.
    @(negedge clk);
    req[1] = 1'b1;
    amt[7:4] = 4'h4;
    repeat (3) @(posedge clk);
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clear = 1'b0;
    chk("abort_score", {16'd0, score}, 32'h0000);
    chk("abort_ovf", {31'd0, ovf}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_ack", {28'd0, ack}, 32'h0);
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (ack[1]) begin
        got = 1'b1;
        req[1] = 1'b0;
      end
    end
    chk("abort_regrant", {31'd0, got}, 32'd1);
    chk("abort_final", {16'd0, score}, 32'h0004);
    chk("abort_final_ovf", {31'd0, ovf}, 32'd0);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
